// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display controller.
//   seg7_t        : active-low segment vector {g,f,e,d,c,b,a}
//   SEG_*         : active-low glyphs for 0..F plus the all-dark pattern
//   digit_entry_t : one register-file entry (value, decimal point, blank)
package display_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_0     = 7'h40;
    localparam seg7_t SEG_1     = 7'h79;
    localparam seg7_t SEG_2     = 7'h24;
    localparam seg7_t SEG_3     = 7'h30;
    localparam seg7_t SEG_4     = 7'h19;
    localparam seg7_t SEG_5     = 7'h12;
    localparam seg7_t SEG_6     = 7'h02;
    localparam seg7_t SEG_7     = 7'h78;
    localparam seg7_t SEG_8     = 7'h00;
    localparam seg7_t SEG_9     = 7'h10;
    localparam seg7_t SEG_A     = 7'h08;
    localparam seg7_t SEG_B     = 7'h03;
    localparam seg7_t SEG_C     = 7'h46;
    localparam seg7_t SEG_D     = 7'h21;
    localparam seg7_t SEG_E     = 7'h06;
    localparam seg7_t SEG_F     = 7'h0E;

    typedef struct packed {
        logic [3:0] val;
        logic       dp;
        logic       blank;
    } digit_entry_t;

    localparam digit_entry_t DIGIT_RESET = '{val: 4'd0, dp: 1'b0, blank: 1'b0};

endpackage

// File: rtl/display_scan_ctrl_seg7_decode.sv
// Combinational hex digit to active-low 7-segment decoder.
//   val : 4-bit digit value (0..F)
//   seg : active-low segments {g,f,e,d,c,b,a}
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    // Glyph lookup; every value is covered, default keeps the bus dark.
    always_comb begin
        seg = SEG_BLANK;
        case (val)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment controller.
// A digit register file is written one entry per cycle; a tick/idx scanner
// lights one digit at a time on a shared active-low segment bus, with a
// dark gap at the start of each slot to suppress ghosting.
//   clock    : system clock (rising edge)
//   reset    : asynchronous active-low reset
//   wr_en    : write strobe
//   wr_pos   : target digit index
//   wr_data  : digit value
//   wr_dp    : decimal point for target digit (1 = lit)
//   wr_blank : 1 = digit dark regardless of value
//   wr_err   : one-cycle pulse, previous-edge write was rejected
//   an       : active-low digit enables
//   seg      : active-low segments {g,f,e,d,c,b,a}
//   dp       : active-low decimal point
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int  NUM_DIGITS   = 8,
    parameter int  PRESCALE     = 1000,
    parameter int  BLANK_CYCLES = 2,
    parameter int  HEX_MODE     = 0,
    localparam int POS_W        = $clog2(NUM_DIGITS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [POS_W-1:0]      wr_pos,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  wr_blank,
    output logic                  wr_err,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int TICK_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(PRESCALE - 1);
    localparam logic [TICK_W-1:0]     GAP_END   = TICK_W'(BLANK_CYCLES);
    localparam logic [POS_W-1:0]      IDX_LAST  = POS_W'(NUM_DIGITS - 1);
    localparam logic [POS_W:0]        NUM_POS   = (POS_W + 1)'(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT   = NUM_DIGITS'(1);

    digit_entry_t          regs_q [NUM_DIGITS];
    digit_entry_t          regs_d [NUM_DIGITS];
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [POS_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg7_t                 seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  wr_err_q, wr_err_d;

    logic                  wr_ok_s;
    logic                  val_ok_s;
    digit_entry_t          cur_s;
    seg7_t                 dec_seg_s;

    // Write validation: position must exist, value must be legal for the mode.
    always_comb begin
        val_ok_s = 1'b0;
        if (HEX_MODE != 0) begin
            val_ok_s = 1'b1;
        end else begin
            val_ok_s = (wr_data < 4'd10);
        end
        wr_ok_s  = wr_en & ({1'b0, wr_pos} < NUM_POS) & val_ok_s;
        wr_err_d = wr_en & ~wr_ok_s;
    end

    // Register-file next state; a rejected write leaves every entry untouched.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_ok_s && (wr_pos == POS_W'(i))) begin
                regs_d[i] = '{val: wr_data, dp: wr_dp, blank: wr_blank};
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Scan counters: tick counts the slot, idx advances on the last tick.
    always_comb begin
        tick_d = tick_q;
        idx_d  = idx_q;
        if (tick_q == TICK_LAST) begin
            tick_d = {TICK_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {POS_W{1'b0}};
            end else begin
                idx_d = idx_q + POS_W'(1'b1);
            end
        end else begin
            tick_d = tick_q + TICK_W'(1'b1);
            idx_d  = idx_q;
        end
    end

    assign cur_s = regs_q[idx_q];

    seg7_decode u_dec (
        .val (cur_s.val),
        .seg (dec_seg_s)
    );

    // Output stage: dark during the ghost gap, otherwise the selected digit.
    always_comb begin
        an_d  = {NUM_DIGITS{1'b1}};
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (tick_q < GAP_END) begin
            an_d  = {NUM_DIGITS{1'b1}};
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(ONE_HOT << idx_q);
            seg_d = cur_s.blank ? SEG_BLANK : dec_seg_s;
            dp_d  = ~(cur_s.dp & ~cur_s.blank);
        end
    end

    // State and output registers with asynchronous clear to the dark state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                regs_q[i] <= DIGIT_RESET;
            end
            tick_q   <= {TICK_W{1'b0}};
            idx_q    <= {POS_W{1'b0}};
            an_q     <= {NUM_DIGITS{1'b1}};
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign an     = an_q;
    assign seg    = seg_q;
    assign dp     = dp_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl.
// Instance A: 8 digits, decimal mode, checked every cycle against a reference
// model through an expectation queue. Instance B: 10 digits, hex mode, used
// for out-of-range position and hex glyph checks.
module tb_display_scan_ctrl;

    localparam int ND = 8;
    localparam int PS = 4;
    localparam int BC = 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic       a_wr_en = 1'b0;
    logic [2:0] a_wr_pos = 3'd0;
    logic [3:0] a_wr_data = 4'd0;
    logic       a_wr_dp = 1'b0;
    logic       a_wr_blank = 1'b0;
    logic       a_wr_err;
    logic [7:0] a_an;
    logic [6:0] a_seg;
    logic       a_dp;

    logic       b_wr_en = 1'b0;
    logic [3:0] b_wr_pos = 4'd0;
    logic [3:0] b_wr_data = 4'd0;
    logic       b_wr_dp = 1'b0;
    logic       b_wr_blank = 1'b0;
    logic       b_wr_err;
    logic [9:0] b_an;
    logic [6:0] b_seg;
    logic       b_dp;

    display_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLANK_CYCLES(BC), .HEX_MODE(0)) dut_a (
        .clock(clock), .reset(reset), .wr_en(a_wr_en), .wr_pos(a_wr_pos),
        .wr_data(a_wr_data), .wr_dp(a_wr_dp), .wr_blank(a_wr_blank),
        .wr_err(a_wr_err), .an(a_an), .seg(a_seg), .dp(a_dp)
    );

    display_scan_ctrl #(.NUM_DIGITS(10), .PRESCALE(PS), .BLANK_CYCLES(BC), .HEX_MODE(1)) dut_b (
        .clock(clock), .reset(reset), .wr_en(b_wr_en), .wr_pos(b_wr_pos),
        .wr_data(b_wr_data), .wr_dp(b_wr_dp), .wr_blank(b_wr_blank),
        .wr_err(b_wr_err), .an(b_an), .seg(b_seg), .dp(b_dp)
    );

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       err;
    } exp_t;

    exp_t       exp_q [$];
    logic [3:0] m_val [ND];
    logic       m_dp [ND];
    logic       m_blank [ND];
    int         m_tick;
    int         m_idx;
    int         n_chk = 0;
    int         n_fail = 0;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_val[i]   = 4'd0;
            m_dp[i]    = 1'b0;
            m_blank[i] = 1'b0;
        end
        m_tick = 0;
        m_idx  = 0;
        exp_q.delete();
    endtask

    task automatic chk_dark_a(input string tag);
        chk({tag, "_an"},  32'(a_an),     32'(8'hFF));
        chk({tag, "_seg"}, 32'(a_seg),    32'(7'h7F));
        chk({tag, "_dp"},  32'(a_dp),     32'(1'b1));
        chk({tag, "_err"}, 32'(a_wr_err), 32'(1'b0));
    endtask

    // One clock of instance A: push the expectation, clock, update model, compare.
    task automatic step();
        exp_t e;
        bit   ok;
        int   p;
        if (m_tick < BC) begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else begin
            e.an  = ~(8'h01 << m_idx);
            e.seg = m_blank[m_idx] ? 7'h7F : glyph(m_val[m_idx]);
            e.dp  = ~(m_dp[m_idx] & ~m_blank[m_idx]);
        end
        p     = int'(a_wr_pos);
        ok    = (p < ND) && (a_wr_data < 4'd10);
        e.err = a_wr_en && !ok;
        exp_q.push_back(e);
        @(posedge clock);
        if (a_wr_en && ok) begin
            m_val[p]   = a_wr_data;
            m_dp[p]    = a_wr_dp;
            m_blank[p] = a_wr_blank;
        end
        if (m_tick == PS - 1) begin
            m_tick = 0;
            m_idx  = (m_idx + 1) % ND;
        end else begin
            m_tick++;
        end
        #1;
        e = exp_q.pop_front();
        chk("an",      32'(a_an),     32'(e.an));
        chk("seg",     32'(a_seg),    32'(e.seg));
        chk("dp",      32'(a_dp),     32'(e.dp));
        chk("wr_err",  32'(a_wr_err), 32'(e.err));
        chk("one_hot", 32'($countones(~a_an)), (e.an == 8'hFF) ? 32'd0 : 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit         found;
        bit         saw_d3;
        logic [7:0] an_prev;

        model_reset();

        // Reset held for three cycles: everything dark, no error.
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk_dark_a("reset");
            chk("reset_b_an", 32'(b_an), 32'(10'h3FF));
            chk("reset_b_dp", 32'(b_dp), 32'(1'b1));
        end
        @(negedge clock);
        reset = 1'b1;
        step();
        step();
        chk("first_lit_an",  32'(a_an),  32'(8'hFE));
        chk("first_lit_seg", 32'(a_seg), 32'(7'h40));

        // Write 5 with dp into digit 3, then watch a full scan.
        a_wr_en = 1'b1; a_wr_pos = 3'd3; a_wr_data = 4'd5; a_wr_dp = 1'b1; a_wr_blank = 1'b0;
        step();
        a_wr_en = 1'b0;
        saw_d3 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (a_an == 8'hF7) begin
                saw_d3 = 1'b1;
                chk("d3_seg", 32'(a_seg), 32'(7'h12));
                chk("d3_dp",  32'(a_dp),  32'(1'b0));
            end
        end
        chk("d3_seen", 32'(saw_d3), 32'(1'b1));

        // Rejected writes: hex value in decimal mode (A), position 10 (B).
        a_wr_en = 1'b1; a_wr_pos = 3'd2; a_wr_data = 4'hB; a_wr_dp = 1'b1;
        b_wr_en = 1'b1; b_wr_pos = 4'd10; b_wr_data = 4'd1;
        step();
        chk("a_err_hex", 32'(a_wr_err), 32'(1'b1));
        chk("b_err_pos", 32'(b_wr_err), 32'(1'b1));
        a_wr_en = 1'b0; a_wr_dp = 1'b0;
        b_wr_pos = 4'd9; b_wr_data = 4'hB;
        step();
        chk("a_err_pulse", 32'(a_wr_err), 32'(1'b0));
        chk("b_err_valid", 32'(b_wr_err), 32'(1'b0));
        b_wr_en = 1'b0;
        step();
        chk("b_err_idle", 32'(b_wr_err), 32'(1'b0));
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (b_an == 10'h1FF) found = 1'b1;
        end
        chk("b_d9_found", 32'(found), 32'(1'b1));
        chk("b_hex_b_seg", 32'(b_seg), 32'(7'h03));
        run(32);

        // Blank the digit currently lit, written on a lit edge.
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (m_tick == 1) found = 1'b1;
            else step();
        end
        chk("lit_slot_found", 32'(found), 32'(1'b1));
        a_wr_en = 1'b1; a_wr_pos = 3'(m_idx); a_wr_data = 4'd7; a_wr_dp = 1'b1; a_wr_blank = 1'b1;
        step();
        a_wr_en = 1'b0; a_wr_blank = 1'b0; a_wr_dp = 1'b0;
        an_prev = a_an;
        step();
        chk("blank_seg", 32'(a_seg), 32'(7'h7F));
        chk("blank_dp",  32'(a_dp),  32'(1'b1));
        chk("blank_an",  32'(a_an),  32'(an_prev));

        // Write on the idx-advance edge: stored, timing unaffected.
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (m_tick == PS - 1) found = 1'b1;
            else step();
        end
        chk("adv_edge_found", 32'(found), 32'(1'b1));
        a_wr_en = 1'b1; a_wr_pos = 3'd0; a_wr_data = 4'd8;
        step();
        a_wr_en = 1'b0;
        run(40);

        // Asynchronous reset at tick 2 of digit 5.
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_idx == 5 && m_tick == 2) found = 1'b1;
            else step();
        end
        chk("d5_t2_found", 32'(found), 32'(1'b1));
        #2;
        reset = 1'b0;
        #1;
        chk_dark_a("async_rst");
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            chk_dark_a("rst_hold");
        end
        @(negedge clock);
        reset = 1'b1;
        step();
        step();
        chk("restart_an",  32'(a_an),  32'(8'hFE));
        chk("restart_seg", 32'(a_seg), 32'(7'h40));
        run(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
